// File: rtl/elastic_buffer_pkg.sv
// -----------------------------------------------------------------------------
// elastic_buffer_pkg
// Shared types and helpers for the elastic buffer:
//   eb_mode_e  - pass mode selection (bypass, fall-through, registered)
//   eb_width() - bit width needed to encode n distinct values (minimum 1)
// -----------------------------------------------------------------------------
package elastic_buffer_pkg;

  typedef enum logic [1:0] {
    EB_BYPASS       = 2'd0,
    EB_FALL_THROUGH = 2'd1,
    EB_REGISTERED   = 2'd2
  } eb_mode_e;

  // Pointers hold 0..DEPTH-1 (eb_width(DEPTH)); the count holds 0..DEPTH
  // (eb_width(DEPTH+1)). Equivalent to $clog2 for n >= 2, but never 0 bits.
  function automatic int unsigned eb_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage : elastic_buffer_pkg

// File: rtl/elastic_buffer_ptr.sv
// -----------------------------------------------------------------------------
// elastic_buffer_ptr
// Modulo-DEPTH wrapping counter used for the read and write pointers.
// DEPTH need not be a power of two; the counter wraps from DEPTH-1 to 0.
// Ports:
//   clk_i  - clock, rising edge
//   rst_i  - asynchronous active-high reset (pointer -> 0)
//   clr_i  - synchronous clear (pointer -> 0), has priority over inc_i
//   inc_i  - advance pointer by one
//   ptr_o  - current pointer value
// -----------------------------------------------------------------------------
module elastic_buffer_ptr
  import elastic_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          clr_i,
  input  logic                          inc_i,
  output logic [eb_width(DEPTH)-1:0]    ptr_o
);

  localparam int unsigned PTR_W = eb_width(DEPTH);

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  // NOTE: ptr_d gets a default before any branch so no path leaves it
  // unassigned; otherwise always_comb would infer a latch.
  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its pre-edge value regardless of process evaluation order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule : elastic_buffer_ptr

// File: rtl/elastic_buffer.sv
// -----------------------------------------------------------------------------
// elastic_buffer
// DEPTH-entry valid/ready decoupling stage with selectable pass mode,
// occupancy reporting, almost-full flag and a flush that is safe against
// concurrent input. In non-bypass modes ready_o depends only on registered
// state, flush_i and rst_i, so the ready path is cut.
// Parameters:
//   DATA_WIDTH   - payload width
//   DEPTH        - storage entries (>= 2, any value)
//   MODE         - EB_BYPASS / EB_FALL_THROUGH / EB_REGISTERED
//   AFULL_THRESH - almost_full_o asserts when count_o >= AFULL_THRESH
// Ports:
//   clk_i, rst_i           - clock, asynchronous active-high reset
//   flush_i                - discard all stored entries
//   valid_i/ready_o/data_i - upstream handshake and payload
//   valid_o/ready_i/data_o - downstream handshake and payload
//   count_o                - registered stored-entry count
//   full_o/empty_o         - count_o == DEPTH / count_o == 0
//   almost_full_o          - count_o >= AFULL_THRESH
// -----------------------------------------------------------------------------
module elastic_buffer
  import elastic_buffer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 2,
  parameter eb_mode_e    MODE         = EB_REGISTERED,
  parameter int unsigned AFULL_THRESH = DEPTH - 1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           flush_i,
  input  logic                           valid_i,
  output logic                           ready_o,
  input  logic [DATA_WIDTH-1:0]          data_i,
  output logic                           valid_o,
  input  logic                           ready_i,
  output logic [DATA_WIDTH-1:0]          data_o,
  output logic [eb_width(DEPTH+1)-1:0]   count_o,
  output logic                           full_o,
  output logic                           empty_o,
  output logic                           almost_full_o
);

  localparam int unsigned PTR_W = eb_width(DEPTH);
  localparam int unsigned CNT_W = eb_width(DEPTH + 1);

  // Elaboration-time parameter checks.
  if (DEPTH < 2) begin : g_chk_depth
    $error("elastic_buffer: DEPTH must be >= 2");
  end
  if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_chk_afull
    $error("elastic_buffer: AFULL_THRESH must be in 1..DEPTH");
  end

  if (MODE == EB_BYPASS) begin : g_bypass
    // Pure wires: no storage, status tied off, flush ignored.
    assign valid_o       = valid_i;
    assign ready_o       = ready_i;
    assign data_o        = data_i;
    assign count_o       = '0;
    assign full_o        = 1'b0;
    assign empty_o       = 1'b1;
    assign almost_full_o = 1'b0;

  end else begin : g_buffered
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      count_d;
    logic [PTR_W-1:0]      wptr;
    logic [PTR_W-1:0]      rptr;
    logic                  empty;
    logic                  full;
    logic                  fall_through;
    logic                  push;
    logic                  pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));

    // Fall-through path is live only while nothing is stored, so ordering
    // is preserved: a new beat can never overtake stored ones.
    assign fall_through = (MODE == EB_FALL_THROUGH) && empty;

    assign ready_o = !full && !flush_i && !rst_i;
    assign valid_o = !flush_i && !rst_i && (fall_through ? valid_i : !empty);
    assign data_o  = (fall_through && !rst_i) ? data_i : mem_q[rptr];

    // A beat that leaves through the fall-through path is never stored.
    assign push = valid_i && ready_o && !(fall_through && ready_i);
    assign pop  = valid_o && ready_i && !empty;

    always_comb begin
      count_d = count_q;
      if (flush_i) begin
        count_d = '0;
      end else if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end
    end

    always_comb begin
      mem_d = mem_q;
      if (push) begin
        mem_d[wptr] = data_i;
      end
    end

    // NOTE: the storage array is reset on purpose so data_o reads 0 after
    // reset; dropping this reset would let stale payload reach data_o.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        count_q <= '0;
        for (int i = 0; i < DEPTH; i++) begin
          mem_q[i] <= '0;
        end
      end else begin
        count_q <= count_d;
        mem_q   <= mem_d;
      end
    end

    // Push and pop are both impossible during flush (ready_o = valid_o = 0),
    // so clear and increment never compete on the same pointer.
    elastic_buffer_ptr #(.DEPTH(DEPTH)) u_wptr (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (flush_i),
      .inc_i (push),
      .ptr_o (wptr)
    );

    elastic_buffer_ptr #(.DEPTH(DEPTH)) u_rptr (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (flush_i),
      .inc_i (pop),
      .ptr_o (rptr)
    );

    assign count_o       = count_q;
    assign full_o        = full;
    assign empty_o       = empty;
    assign almost_full_o = (count_q >= CNT_W'(AFULL_THRESH));
  end

endmodule : elastic_buffer

// File: tb/tb_elastic_buffer.sv
// -----------------------------------------------------------------------------
// tb_elastic_buffer
// Directed bench for elastic_buffer. Four instances share clock and reset:
//   u_reg - DEPTH=3, EB_REGISTERED (AFULL_THRESH default 2)
//   u_ft  - DEPTH=3, EB_FALL_THROUGH
//   u_af  - DEPTH=4, EB_REGISTERED, AFULL_THRESH=3
//   u_by  - DEPTH=2, EB_BYPASS
// Inputs change just after the falling edge; outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_elastic_buffer;
  import elastic_buffer_pkg::*;

  localparam int unsigned DW = 8;

  logic clk;
  logic rst;

  // u_reg
  logic          r_valid_i, r_ready_i, r_flush_i;
  logic [DW-1:0] r_data_i;
  logic          r_ready_o, r_valid_o, r_full_o, r_empty_o, r_af_o;
  logic [DW-1:0] r_data_o;
  logic [1:0]    r_count_o;
  // u_ft
  logic          f_valid_i, f_ready_i, f_flush_i;
  logic [DW-1:0] f_data_i;
  logic          f_ready_o, f_valid_o, f_full_o, f_empty_o, f_af_o;
  logic [DW-1:0] f_data_o;
  logic [1:0]    f_count_o;
  // u_af
  logic          a_valid_i, a_ready_i, a_flush_i;
  logic [DW-1:0] a_data_i;
  logic          a_ready_o, a_valid_o, a_full_o, a_empty_o, a_af_o;
  logic [DW-1:0] a_data_o;
  logic [2:0]    a_count_o;
  // u_by
  logic          b_valid_i, b_ready_i, b_flush_i;
  logic [DW-1:0] b_data_i;
  logic          b_ready_o, b_valid_o, b_full_o, b_empty_o, b_af_o;
  logic [DW-1:0] b_data_o;
  logic [1:0]    b_count_o;

  int n_checks = 0;
  int n_errors = 0;

  elastic_buffer #(.DATA_WIDTH(DW), .DEPTH(3), .MODE(EB_REGISTERED)) u_reg (
    .clk_i(clk), .rst_i(rst), .flush_i(r_flush_i),
    .valid_i(r_valid_i), .ready_o(r_ready_o), .data_i(r_data_i),
    .valid_o(r_valid_o), .ready_i(r_ready_i), .data_o(r_data_o),
    .count_o(r_count_o), .full_o(r_full_o), .empty_o(r_empty_o),
    .almost_full_o(r_af_o)
  );

  elastic_buffer #(.DATA_WIDTH(DW), .DEPTH(3), .MODE(EB_FALL_THROUGH)) u_ft (
    .clk_i(clk), .rst_i(rst), .flush_i(f_flush_i),
    .valid_i(f_valid_i), .ready_o(f_ready_o), .data_i(f_data_i),
    .valid_o(f_valid_o), .ready_i(f_ready_i), .data_o(f_data_o),
    .count_o(f_count_o), .full_o(f_full_o), .empty_o(f_empty_o),
    .almost_full_o(f_af_o)
  );

  elastic_buffer #(.DATA_WIDTH(DW), .DEPTH(4), .MODE(EB_REGISTERED),
                   .AFULL_THRESH(3)) u_af (
    .clk_i(clk), .rst_i(rst), .flush_i(a_flush_i),
    .valid_i(a_valid_i), .ready_o(a_ready_o), .data_i(a_data_i),
    .valid_o(a_valid_o), .ready_i(a_ready_i), .data_o(a_data_o),
    .count_o(a_count_o), .full_o(a_full_o), .empty_o(a_empty_o),
    .almost_full_o(a_af_o)
  );

  elastic_buffer #(.DATA_WIDTH(DW), .DEPTH(2), .MODE(EB_BYPASS)) u_by (
    .clk_i(clk), .rst_i(rst), .flush_i(b_flush_i),
    .valid_i(b_valid_i), .ready_o(b_ready_o), .data_i(b_data_i),
    .valid_o(b_valid_o), .ready_i(b_ready_i), .data_o(b_data_o),
    .count_o(b_count_o), .full_o(b_full_o), .empty_o(b_empty_o),
    .almost_full_o(b_af_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance to the next falling edge (inputs are applied right after it).
  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    {r_valid_i, r_ready_i, r_flush_i} = '0; r_data_i = '0;
    {f_valid_i, f_ready_i, f_flush_i} = '0; f_data_i = '0;
    {a_valid_i, a_ready_i, a_flush_i} = '0; a_data_i = '0;
    {b_valid_i, b_ready_i, b_flush_i} = '0; b_data_i = '0;

    // ---------------- reset state ----------------
    next_cycle(); #1;
    check("rst_ready",  32'(r_ready_o), 32'd0);
    check("rst_valid",  32'(r_valid_o), 32'd0);
    check("rst_count",  32'(r_count_o), 32'd0);
    check("rst_empty",  32'(r_empty_o), 32'd1);
    check("rst_full",   32'(r_full_o),  32'd0);
    check("rst_afull",  32'(r_af_o),    32'd0);
    check("rst_data",   32'(r_data_o),  32'd0);
    check("rst_ft_valid", 32'(f_valid_o), 32'd0);

    next_cycle(); rst = 1'b0; #1;
    check("post_rst_ready", 32'(r_ready_o), 32'd1);

    // ---------------- fill DEPTH=3 with ready_i low ----------------
    r_valid_i = 1'b1; r_data_i = 8'hA1; #1;
    check("fill_ready0", 32'(r_ready_o), 32'd1);
    next_cycle(); #1;
    check("fill1_count", 32'(r_count_o), 32'd1);
    check("fill1_valid", 32'(r_valid_o), 32'd1);
    check("fill1_data",  32'(r_data_o),  32'hA1);
    r_data_i = 8'hA2;
    next_cycle(); #1;
    check("fill2_count", 32'(r_count_o), 32'd2);
    check("fill2_afull", 32'(r_af_o),    32'd1);
    r_data_i = 8'hA3;
    next_cycle(); #1;
    check("fill3_count", 32'(r_count_o), 32'd3);
    check("fill3_full",  32'(r_full_o),  32'd1);
    check("fill3_ready", 32'(r_ready_o), 32'd0);
    r_data_i = 8'hA4;
    next_cycle(); #1;
    check("a4_rejected_count", 32'(r_count_o), 32'd3);
    check("a4_rejected_data",  32'(r_data_o),  32'hA1);

    // Full with valid_i=1 and ready_i=1: one pop, no push.
    r_ready_i = 1'b1; #1;
    check("full_rdy_valid", 32'(r_valid_o), 32'd1);
    check("full_rdy_data",  32'(r_data_o),  32'hA1);
    check("full_rdy_ready", 32'(r_ready_o), 32'd0);
    next_cycle(); r_valid_i = 1'b0; #1;
    check("drain1_count", 32'(r_count_o), 32'd2);
    check("drain1_ready", 32'(r_ready_o), 32'd1);
    check("drain1_full",  32'(r_full_o),  32'd0);
    check("drain1_data",  32'(r_data_o),  32'hA2);
    next_cycle(); #1;
    check("drain2_data",  32'(r_data_o),  32'hA3);
    check("drain2_count", 32'(r_count_o), 32'd1);
    next_cycle(); #1;
    check("drain3_valid", 32'(r_valid_o), 32'd0);
    check("drain3_empty", 32'(r_empty_o), 32'd1);

    // ---------------- streaming across pointer wrap ----------------
    for (int i = 0; i <= 10; i++) begin
      if (i < 10) begin
        r_valid_i = 1'b1; r_data_i = 8'(i);
      end else begin
        r_valid_i = 1'b0;
      end
      #1;
      if (i > 0) begin
        check("stream_valid", 32'(r_valid_o), 32'd1);
        check("stream_data",  32'(r_data_o),  32'(i - 1));
        check("stream_count", 32'(r_count_o), 32'd1);
      end
      next_cycle();
    end
    #1;
    check("stream_end_empty", 32'(r_empty_o), 32'd1);

    // ---------------- flush with concurrent input ----------------
    r_ready_i = 1'b0; r_valid_i = 1'b1; r_data_i = 8'hB1;
    next_cycle(); r_data_i = 8'hB2;
    next_cycle(); #1;
    check("preflush_count", 32'(r_count_o), 32'd2);
    r_flush_i = 1'b1; r_data_i = 8'h77; #1;
    check("flush_ready", 32'(r_ready_o), 32'd0);
    check("flush_valid", 32'(r_valid_o), 32'd0);
    next_cycle(); r_flush_i = 1'b0; r_valid_i = 1'b0; r_ready_i = 1'b1; #1;
    check("postflush_count", 32'(r_count_o), 32'd0);
    check("postflush_empty", 32'(r_empty_o), 32'd1);
    check("postflush_valid", 32'(r_valid_o), 32'd0);
    next_cycle(); #1;
    check("no_0x77_valid", 32'(r_valid_o), 32'd0);
    r_valid_i = 1'b1; r_data_i = 8'hC1;
    next_cycle(); r_valid_i = 1'b0; #1;
    check("postflush_push_data", 32'(r_data_o), 32'hC1);
    next_cycle(); #1;
    check("postflush_drained", 32'(r_empty_o), 32'd1);

    // ---------------- asynchronous reset mid-stream ----------------
    r_ready_i = 1'b0; r_valid_i = 1'b1; r_data_i = 8'hD1;
    next_cycle(); r_data_i = 8'hD2;
    next_cycle(); r_valid_i = 1'b0; #1;
    check("prerst_count", 32'(r_count_o), 32'd2);
    #1 rst = 1'b1; #1;
    check("async_rst_valid", 32'(r_valid_o), 32'd0);
    check("async_rst_ready", 32'(r_ready_o), 32'd0);
    check("async_rst_count", 32'(r_count_o), 32'd0);
    check("async_rst_data",  32'(r_data_o),  32'd0);
    next_cycle(); rst = 1'b0; r_ready_i = 1'b1; #1;
    check("rel_ready", 32'(r_ready_o), 32'd1);
    check("rel_valid", 32'(r_valid_o), 32'd0);
    next_cycle(); #1;
    check("rel_no_stale", 32'(r_valid_o), 32'd0);

    // ---------------- fall-through ----------------
    f_valid_i = 1'b1; f_data_i = 8'h55; f_ready_i = 1'b1; #1;
    check("ft_valid", 32'(f_valid_o), 32'd1);
    check("ft_data",  32'(f_data_o),  32'h55);
    next_cycle(); f_valid_i = 1'b0; #1;
    check("ft_count0", 32'(f_count_o), 32'd0);
    check("ft_idle_valid", 32'(f_valid_o), 32'd0);
    f_ready_i = 1'b0; f_valid_i = 1'b1; f_data_i = 8'h66; #1;
    check("ft_blocked_data", 32'(f_data_o), 32'h66);
    next_cycle(); f_data_i = 8'h67; #1;
    check("ft_stored_count", 32'(f_count_o), 32'd1);
    check("ft_stored_data",  32'(f_data_o),  32'h66);
    next_cycle(); f_valid_i = 1'b0; f_ready_i = 1'b1; #1;
    check("ft_order_data", 32'(f_data_o), 32'h66);
    next_cycle(); #1;
    check("ft_order_data2", 32'(f_data_o), 32'h67);
    next_cycle(); #1;
    check("ft_drained", 32'(f_empty_o), 32'd1);

    // ---------------- almost-full, DEPTH=4, threshold 3 ----------------
    a_valid_i = 1'b1; a_data_i = 8'h01;
    next_cycle(); a_data_i = 8'h02;
    next_cycle(); #1;
    check("af_at2", 32'(a_af_o), 32'd0);
    a_data_i = 8'h03;
    next_cycle(); a_valid_i = 1'b0; #1;
    check("af_at3",    32'(a_af_o),    32'd1);
    check("af_count3", 32'(a_count_o), 32'd3);
    check("af_notfull", 32'(a_full_o), 32'd0);
    a_ready_i = 1'b1;
    next_cycle(); a_ready_i = 1'b0; #1;
    check("af_after_pop", 32'(a_af_o),    32'd0);
    check("af_count2",    32'(a_count_o), 32'd2);

    // ---------------- bypass ----------------
    b_valid_i = 1'b1; b_data_i = 8'h3C; b_ready_i = 1'b0; b_flush_i = 1'b1; #1;
    check("by_valid", 32'(b_valid_o), 32'd1);
    check("by_ready", 32'(b_ready_o), 32'd0);
    check("by_data",  32'(b_data_o),  32'h3C);
    b_ready_i = 1'b1; #1;
    check("by_ready_follow", 32'(b_ready_o), 32'd1);
    next_cycle(); #1;
    check("by_empty", 32'(b_empty_o), 32'd1);
    check("by_count", 32'(b_count_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_elastic_buffer

// File: doc/elastic_buffer.md
# elastic_buffer

Parametrised next-generation spill/elastic buffer: a DEPTH-entry valid/ready decoupling stage with selectable pass mode, occupancy reporting, an almost-full flag and a flush that is safe against concurrent input. It sits on any valid/ready datapath between producer and consumer. It cuts the ready path in every non-bypass mode, because ready_o depends only on registered state, flush_i and rst_i, never on ready_i. It is also used as a small rate-matching buffer in front of slow consumers.

## Interface
- DATA_WIDTH, 32, payload width in bits (≥1)
- DEPTH, 2, number of storage entries (≥2; need not be a power of two)
- MODE, EB_REGISTERED, eb_mode_e: EB_BYPASS, EB_FALL_THROUGH or EB_REGISTERED
- AFULL_THRESH, DEPTH-1, almost_full_o asserts when count ≥ AFULL_THRESH (1..DEPTH)
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset; asynchronous, active-high
- flush_i  in  1  discard all stored entries
- valid_i  in  1  upstream valid
- ready_o  out  1  upstream ready
- data_i  in  DATA_WIDTH  upstream payload
- valid_o  out  1  downstream valid
- ready_i  in  1  downstream ready
- data_o  out  DATA_WIDTH  downstream payload
- count_o  out  $clog2(DEPTH+1)  stored-entry count, registered
- full_o  out  1  count_o == DEPTH
- empty_o  out  1  count_o == 0
- almost_full_o  out  1  count_o ≥ AFULL_THRESH

## Operation
- Storage is a circular array of DEPTH entries, with write pointer wptr and read pointer rptr, each $clog2(DEPTH) bits wide. Each pointer wraps from DEPTH-1 to 0; no power-of-two assumption is made.
- Push: a push occurs when valid_i && ready_o, provided the beat is not consumed by fall-through. The entry is written at wptr, and wptr advances.
- Pop: a pop occurs when valid_o && ready_i and the buffer is non-empty. rptr advances.
- Count update: count' = count + push − pop. A simultaneous push and pop leaves count unchanged.
- ready_o = !full_o && !flush_i && !rst_i. A full buffer never accepts input, even when ready_i is high in the same cycle.
- EB_REGISTERED: valid_o = !empty_o; data_o = mem[rptr].
- EB_FALL_THROUGH, buffer empty: valid_o = valid_i and data_o = data_i. If ready_i is high, the beat passes without being written and count stays 0. If ready_i is low, the beat is pushed.
- EB_FALL_THROUGH, buffer non-empty: behaves as EB_REGISTERED.
- EB_BYPASS: valid_o = valid_i, ready_o = ready_i, data_o = data_i. No storage is instantiated. count_o, full_o and almost_full_o are tied to 0; empty_o is tied to 1. flush_i is ignored.
- Flush (non-bypass modes): while flush_i is high, ready_o = 0 and valid_o = 0, so no handshake can occur. On the next edge, count, wptr and rptr are all cleared to 0. Asserting valid_i during a flush is legal; the beat is simply not accepted.
- Payload ordering is strictly FIFO. valid_o, once high, stays high until a pop, flush or reset.

## Timing
- Reset (rst_i high, asynchronously), non-bypass modes:
  - count_o = 0, full_o = 0, empty_o = 1, almost_full_o = 0.
  - valid_o = 0, ready_o = 0.
  - Stored data and data_o are set to 0.
- First cycle after rst_i deasserts: ready_o = 1.
- Latency, EB_REGISTERED: a beat pushed at edge N appears on valid_o/data_o after edge N (1 cycle).
- Latency, EB_FALL_THROUGH: 0 cycles when empty; otherwise 1 cycle.
- Throughput is 1 beat per cycle in steady state, including when full with ready_i high. That cycle pops; the freed slot raises ready_o in the next cycle.
- Status outputs are registered-derived: count_o, full_o, empty_o and almost_full_o update on the edge after the handshake.
- Reset asserted mid-transfer drops all contents immediately; no partial beat survives.

## Structure
- elastic_buffer_pkg holds:
  - typedef enum eb_mode_e {EB_BYPASS, EB_FALL_THROUGH, EB_REGISTERED}
  - the pointer/count width helper function
- Sub-module elastic_buffer_ptr: a modulo-DEPTH wrapping counter with inc and clr inputs and an asynchronous active-high reset. It is instantiated for wptr and rptr.
- Elaboration-time checks: DEPTH ≥ 2; 1 ≤ AFULL_THRESH ≤ DEPTH.

## Test plan
- DEPTH=3, EB_REGISTERED, ready_i=0, push 0xA1, 0xA2, 0xA3, then 0xA4 -> count_o reaches 3, full_o=1, ready_o=0 and 0xA4 is not accepted. Then set ready_i=1 -> output is 0xA1, 0xA2, 0xA3 in order, one per cycle.
- DEPTH=3, full, with valid_i=1 and ready_i=1 for one cycle -> exactly one pop, no push; count_o goes 3→2; ready_o=1 in the next cycle. Run continuous streaming afterwards to check wrap-around across 10 beats, with data equal to its index.
- EB_FALL_THROUGH, empty, valid_i=1, data_i=0x55, ready_i=1 -> same cycle valid_o=1 and data_o=0x55; count_o remains 0.
- Two entries stored, then flush_i=1 for one cycle with valid_i=1, data_i=0x77 -> in that cycle ready_o=0 and valid_o=0. Next cycle count_o=0 and empty_o=1. 0x77 is never output.
- DEPTH=4, AFULL_THRESH=3, push 3 beats -> almost_full_o rises on the edge after the 3rd push and falls after the first pop.
- Assert rst_i asynchronously mid-stream with 2 stored entries -> valid_o=0, ready_o=0 and count_o=0 immediately. After release, ready_o=1 and no stale data appears on valid_o.
